pipe_ctrl: RTL and testbench
============================

Name: pipe_ctrl

Overview:
- Pipeline control unit that drives the per-stage hold vector and flush vector consumed by the pc, if_id, id_ex, ex_mem and mem_wb stage registers.
- Arbitrates stall requests from ID, EX and MEM, branch/jump redirects from EX, and trap entry.
- Owns the multi-cycle sequencing: post-redirect flush window and trap drain/redirect.
- Bit index of every 5-bit vector: 0=pc, 1=if_id, 2=id_ex, 3=ex_mem, 4=mem_wb.
  - hold=1 means the stage register keeps its value.
  - flush=1 means the stage register loads NOP/zero on the next edge.

Parameters:
- JUMP_FLUSH_CYCLES, 1, extra cycles (1..7) if_id is flushed after a redirect, to cover fetch latency.
- ADDR_W, 32, redirect address width.

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- id_hold_req_i  in  1  load-use hazard; one bubble needed
- ex_hold_req_i  in  1  multi-cycle EX op busy
- mem_hold_req_i  in  1  data-bus wait
- ex_jump_en_i  in  1  EX resolved redirect (mispredict/jump)
- ex_jump_addr_i  in  ADDR_W  redirect target
- int_req_i  in  1  trap request (level, held until acked)
- int_addr_i  in  ADDR_W  trap vector
- hold_en_o  out  5  per-stage hold
- flush_o  out  5  per-stage flush
- jump_en_o  out  1  pc redirect strobe
- jump_addr_o  out  ADDR_W  pc redirect target
- int_ack_o  out  1  one-cycle trap-taken pulse
- busy_o  out  1  state != IDLE

Behaviour:
- Clock and reset: all state on clk rising edge; rstn low asynchronously forces state=IDLE, flush counter=0, int_ack_o=0.
- Outputs while in reset: hold_en_o=0, flush_o=0, jump_en_o=0, jump_addr_o=0, busy_o=0.
- hold_en_o/flush_o/jump_* are combinational from inputs and registered state. Request priority is mem > ex > jump > trap > id.
- mem_hold_req_i: hold_en_o=5'b01111, flush_o=5'b10000 (bubble into mem_wb). Jump and trap are ignored and must be re-presented.
- ex_hold_req_i (no mem hold): hold_en_o=5'b00111, flush_o=5'b01000.
- ex_jump_en_i (no holds): jump_en_o=1, jump_addr_o=ex_jump_addr_i, flush_o=5'b00110, hold_en_o=0. Next state is FLUSH with cnt=JUMP_FLUSH_CYCLES.
- id_hold_req_i (nothing higher): hold_en_o=5'b00011, flush_o=5'b00100. Lasts one cycle per request cycle.
- FSM states:
  - IDLE: applies the priority rules above.
  - FLUSH: flush_o[1]=1 each cycle, cnt decrements, back to IDLE when cnt reaches 1.
    - A new ex_jump_en_i in FLUSH restarts: new redirect and cnt reloaded.
    - Holds in FLUSH still apply and freeze cnt; flush_o[1] stays asserted.
  - TRAP_DRAIN: entered from IDLE when int_req_i=1 and no hold/jump is present.
    - hold_en_o=5'b00011 and flush_o=5'b00100 while in-flight EX/MEM/WB retire.
    - Waits 3 hold-free cycles (2-bit drain counter, frozen by mem/ex holds).
    - An ex_jump_en_i during drain is flushed (flush_o=5'b00110) without redirect.
  - TRAP_REDIR: one cycle with jump_en_o=1, jump_addr_o=int_addr_i, flush_o=5'b00110, int_ack_o=1. Then FLUSH with cnt=JUMP_FLUSH_CYCLES.
- int_req_i arriving in FLUSH is deferred until IDLE.
- int_req_i must not be dropped before ack. If it is dropped mid-drain, return to IDLE without ack.
- Simultaneous id_hold_req_i with jump: jump wins; the hazard instruction is flushed anyway.
- busy_o=1 in FLUSH, TRAP_DRAIN, TRAP_REDIR.

Optional Feature:
- PIPE_CTRL_PERF_CNT_EN defined: adds outputs stall_cnt_o[31:0] and flush_cnt_o[31:0].
  - stall_cnt_o increments each cycle hold_en_o[0]=1.
  - flush_cnt_o increments on each jump_en_o pulse.
  - Both saturate at 32'hFFFF_FFFF and reset to 0.
- Undefined: ports and counters absent. Logic is otherwise identical.

Test Plan:
- Reset: rstn=0 mid-FLUSH with cnt=1 -> all outputs 0 immediately, busy_o=0 after release.
- Load-use: id_hold_req_i=1 for 1 cycle -> hold_en_o=5'b00011, flush_o=5'b00100 that cycle, then 0.
- Jump with JUMP_FLUSH_CYCLES=2, ex_jump_addr_i=32'h0000_0100:
  - cycle 0: jump_en_o=1, jump_addr_o=32'h100, flush_o=5'b00110.
  - next 2 cycles: flush_o=5'b00010.
  - then IDLE.
- mem_hold_req_i=1 for 3 cycles concurrent with ex_jump_en_i:
  - hold_en_o=5'b01111 for 3 cycles, no jump_en_o.
  - jump taken on the 4th cycle when re-presented.
- Trap: int_req_i=1, int_addr_i=32'h8000_0004, no holds:
  - 3 drain cycles with hold_en_o=5'b00011.
  - then jump_en_o=1 to 32'h8000_0004 with int_ack_o=1 for exactly 1 cycle.
  - then FLUSH.
- Trap drain with ex_hold_req_i=1 for 2 cycles inside drain -> drain extends to 5 cycles total before TRAP_REDIR.

Source files
------------

// File: rtl/pipe_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_ctrl -- pipeline hold/flush/redirect control unit
//
// Drives the per-stage hold and flush vectors for the five stage registers
// (bit 0=pc, 1=if_id, 2=id_ex, 3=ex_mem, 4=mem_wb). It arbitrates stall
// requests (priority mem > ex > jump > trap > id) and sequences the
// post-redirect flush window and the trap drain/redirect.
//
// Parameters:
//   JUMP_FLUSH_CYCLES  extra cycles (1..7) if_id is flushed after a redirect
//   ADDR_W             redirect address width
//
// Ports:
//   clk              clock
//   rstn             asynchronous active-low reset
//   id_hold_req_i    load-use hazard, one bubble per request cycle
//   ex_hold_req_i    multi-cycle EX op busy
//   mem_hold_req_i   data-bus wait
//   ex_jump_en_i     EX-resolved redirect
//   ex_jump_addr_i   redirect target
//   int_req_i        trap request (level, held until acked)
//   int_addr_i       trap vector
//   hold_en_o        per-stage hold
//   flush_o          per-stage flush
//   jump_en_o        pc redirect strobe
//   jump_addr_o      pc redirect target
//   int_ack_o        one-cycle trap-taken pulse
//   busy_o           controller is not idle
//
// Optional build macro PIPE_CTRL_PERF_CNT_EN adds saturating performance
// counters stall_cnt_o (cycles with the pc held) and flush_cnt_o (redirects).
// ---------------------------------------------------------------------------
module pipe_ctrl #(
  parameter int unsigned JUMP_FLUSH_CYCLES = 1,
  parameter int unsigned ADDR_W            = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              id_hold_req_i,
  input  logic              ex_hold_req_i,
  input  logic              mem_hold_req_i,
  input  logic              ex_jump_en_i,
  input  logic [ADDR_W-1:0] ex_jump_addr_i,
  input  logic              int_req_i,
  input  logic [ADDR_W-1:0] int_addr_i,
  output logic [4:0]        hold_en_o,
  output logic [4:0]        flush_o,
  output logic              jump_en_o,
  output logic [ADDR_W-1:0] jump_addr_o,
  output logic              int_ack_o,
`ifdef PIPE_CTRL_PERF_CNT_EN
  output logic [31:0]       stall_cnt_o,
  output logic [31:0]       flush_cnt_o,
`endif
  output logic              busy_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FLUSH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_REDIR = 2'd3
  } state_e;

  localparam logic [2:0] FLUSH_LOAD = 3'(JUMP_FLUSH_CYCLES);

  localparam logic [4:0] HOLD_MEM  = 5'b01111;
  localparam logic [4:0] FLUSH_MEM = 5'b10000;
  localparam logic [4:0] HOLD_EX   = 5'b00111;
  localparam logic [4:0] FLUSH_EX  = 5'b01000;
  localparam logic [4:0] HOLD_ID   = 5'b00011;
  localparam logic [4:0] FLUSH_ID  = 5'b00100;
  localparam logic [4:0] FLUSH_JMP = 5'b00110;
  localparam logic [4:0] FLUSH_IF  = 5'b00010;

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [1:0]  drain_q, drain_d;
  logic        int_ack_q, int_ack_d;

  logic [4:0]        hold_c;
  logic [4:0]        flush_c;
  logic              jump_en_c;
  logic [ADDR_W-1:0] jump_addr_c;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 3'd0;
      drain_q   <= 2'd0;
      int_ack_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      drain_q   <= drain_d;
      int_ack_q <= int_ack_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    drain_d     = drain_q;
    int_ack_d   = 1'b0;
    hold_c      = 5'b00000;
    flush_c     = 5'b00000;
    jump_en_c   = 1'b0;
    jump_addr_c = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (mem_hold_req_i) begin
          hold_c  = HOLD_MEM;
          flush_c = FLUSH_MEM;
        end else if (ex_hold_req_i) begin
          hold_c  = HOLD_EX;
          flush_c = FLUSH_EX;
        end else if (ex_jump_en_i) begin
          // A simultaneous load-use hazard is covered: id_ex is flushed here.
          jump_en_c   = 1'b1;
          jump_addr_c = ex_jump_addr_i;
          flush_c     = FLUSH_JMP;
          state_d     = ST_FLUSH;
          cnt_d       = FLUSH_LOAD;
        end else if (int_req_i) begin
          state_d = ST_DRAIN;
          drain_d = 2'd0;
        end else if (id_hold_req_i) begin
          hold_c  = HOLD_ID;
          flush_c = FLUSH_ID;
        end
      end

      ST_FLUSH: begin
        // if_id keeps flushing for the whole window; holds freeze the count.
        // Trap requests wait until the window closes.
        if (mem_hold_req_i) begin
          hold_c  = HOLD_MEM;
          flush_c = FLUSH_MEM | FLUSH_IF;
        end else if (ex_hold_req_i) begin
          hold_c  = HOLD_EX;
          flush_c = FLUSH_EX | FLUSH_IF;
        end else if (ex_jump_en_i) begin
          jump_en_c   = 1'b1;
          jump_addr_c = ex_jump_addr_i;
          flush_c     = FLUSH_JMP;
          cnt_d       = FLUSH_LOAD;
        end else if (id_hold_req_i) begin
          hold_c  = HOLD_ID;
          flush_c = FLUSH_ID | FLUSH_IF;
        end else begin
          flush_c = FLUSH_IF;
          if (cnt_q <= 3'd1) begin
            state_d = ST_IDLE;
            cnt_d   = 3'd0;
          end else begin
            cnt_d = cnt_q - 3'd1;
          end
        end
      end

      ST_DRAIN: begin
        // Front end frozen while EX/MEM/WB retire; a redirect from EX is
        // squashed without being taken since the trap supersedes it.
        if (mem_hold_req_i) begin
          hold_c  = HOLD_MEM;
          flush_c = FLUSH_MEM;
        end else if (ex_hold_req_i) begin
          hold_c  = HOLD_EX;
          flush_c = FLUSH_EX;
        end else if (ex_jump_en_i) begin
          hold_c  = HOLD_ID;
          flush_c = FLUSH_JMP;
        end else begin
          hold_c  = HOLD_ID;
          flush_c = FLUSH_ID;
        end

        if (!int_req_i) begin
          state_d = ST_IDLE;
          drain_d = 2'd0;
        end else if (!(mem_hold_req_i || ex_hold_req_i)) begin
          if (drain_q == 2'd2) begin
            state_d   = ST_REDIR;
            drain_d   = 2'd0;
            int_ack_d = 1'b1;
          end else begin
            drain_d = drain_q + 2'd1;
          end
        end
      end

      ST_REDIR: begin
        jump_en_c   = 1'b1;
        jump_addr_c = int_addr_i;
        flush_c     = FLUSH_JMP;
        state_d     = ST_FLUSH;
        cnt_d       = FLUSH_LOAD;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Reset gates the combinational outputs so the stages see no activity
  // while rstn is low, regardless of the request inputs.
  assign hold_en_o   = rstn ? hold_c      : 5'b00000;
  assign flush_o     = rstn ? flush_c     : 5'b00000;
  assign jump_en_o   = rstn ? jump_en_c   : 1'b0;
  assign jump_addr_o = rstn ? jump_addr_c : '0;
  assign int_ack_o   = int_ack_q;
  assign busy_o      = rstn && (state_q != ST_IDLE);

`ifdef PIPE_CTRL_PERF_CNT_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      if (hold_en_o[0] && (stall_cnt_q != 32'hFFFF_FFFF)) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
      if (jump_en_o && (flush_cnt_q != 32'hFFFF_FFFF)) begin
        flush_cnt_q <= flush_cnt_q + 32'd1;
      end
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_ctrl -- directed self-checking bench for pipe_ctrl
// (JUMP_FLUSH_CYCLES=2). Inputs change on the falling edge and outputs are
// sampled 1ns later, well away from the rising edge.
// Observed vector: {hold_en_o[4:0], flush_o[4:0], jump_en_o, int_ack_o, busy_o}
// ---------------------------------------------------------------------------
module tb_pipe_ctrl;

  localparam int ADDR_W = 32;

  logic              clk = 1'b0;
  logic              rstn;
  logic              id_hold_req_i, ex_hold_req_i, mem_hold_req_i;
  logic              ex_jump_en_i, int_req_i;
  logic [ADDR_W-1:0] ex_jump_addr_i, int_addr_i;
  logic [4:0]        hold_en_o, flush_o;
  logic              jump_en_o, int_ack_o, busy_o;
  logic [ADDR_W-1:0] jump_addr_o;
`ifdef PIPE_CTRL_PERF_CNT_EN
  logic [31:0]       stall_cnt_o, flush_cnt_o;
`endif

  logic [12:0] obs;
  assign obs = {hold_en_o, flush_o, jump_en_o, int_ack_o, busy_o};

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipe_ctrl #(.JUMP_FLUSH_CYCLES(2), .ADDR_W(ADDR_W)) dut (
    .clk            (clk),
    .rstn           (rstn),
    .id_hold_req_i  (id_hold_req_i),
    .ex_hold_req_i  (ex_hold_req_i),
    .mem_hold_req_i (mem_hold_req_i),
    .ex_jump_en_i   (ex_jump_en_i),
    .ex_jump_addr_i (ex_jump_addr_i),
    .int_req_i      (int_req_i),
    .int_addr_i     (int_addr_i),
    .hold_en_o      (hold_en_o),
    .flush_o        (flush_o),
    .jump_en_o      (jump_en_o),
    .jump_addr_o    (jump_addr_o),
    .int_ack_o      (int_ack_o),
`ifdef PIPE_CTRL_PERF_CNT_EN
    .stall_cnt_o    (stall_cnt_o),
    .flush_cnt_o    (flush_cnt_o),
`endif
    .busy_o         (busy_o)
  );

  // Stimulus row packing: {mem, ex, jump, int, id}
  task automatic drive(input logic [4:0] s);
    {mem_hold_req_i, ex_hold_req_i, ex_jump_en_i, int_req_i, id_hold_req_i} = s;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    drive(5'b00100);
    ex_jump_addr_i = 32'h0000_0100;
    @(negedge clk); #1;
    total++;
    if (obs !== 13'b0 || jump_addr_o !== '0) begin
      $display("FAIL reset_hold obs=%b addr=%h want obs=0 addr=0", obs, jump_addr_o); bad++;
    end
    drive(5'b00000);
    @(negedge clk); rstn = 1'b1; #1;
    total++;
    if (obs !== 13'b0) begin
      $display("FAIL reset_release obs=%b want 0", obs); bad++;
    end
    // Enter FLUSH, then reset while cnt=1.
    @(negedge clk); drive(5'b00100); #1;
    @(negedge clk); drive(5'b00000); #1;
    total++;
    if (obs !== {5'b00000, 5'b00010, 3'b001}) begin
      $display("FAIL reset_pre_flush obs=%b want %b", obs, {5'b00000, 5'b00010, 3'b001}); bad++;
    end
    @(negedge clk); rstn = 1'b0; #1;
    total++;
    if (obs !== 13'b0) begin
      $display("FAIL reset_mid_flush obs=%b want 0", obs); bad++;
    end
    @(negedge clk); rstn = 1'b1; #1;
    total++;
    if (obs !== 13'b0) begin
      $display("FAIL reset_after_flush obs=%b want 0 (busy must be 0)", obs); bad++;
    end
    $display("test_reset complete");
  endtask

  task automatic test_load_use();
    logic [4:0]  stim [2] = '{5'b00001, 5'b00000};
    logic [12:0] exp  [2] = '{{5'b00011, 5'b00100, 3'b000}, 13'b0};
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); drive(stim[i]); #1;
      total++;
      if (obs !== exp[i]) begin
        $display("FAIL load_use[%0d] obs=%b want %b", i, obs, exp[i]); bad++;
      end
    end
    $display("test_load_use complete");
  endtask

  task automatic test_jump();
    logic [4:0]  stim [4] = '{5'b00100, 5'b00000, 5'b00000, 5'b00000};
    logic [12:0] exp  [4] = '{{5'b00000, 5'b00110, 3'b100}, {5'b00000, 5'b00010, 3'b001},
                              {5'b00000, 5'b00010, 3'b001}, 13'b0};
    ex_jump_addr_i = 32'h0000_0100;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); drive(stim[i]); #1;
      total++;
      if (obs !== exp[i] || (exp[i][2] && jump_addr_o !== 32'h0000_0100)) begin
        $display("FAIL jump[%0d] obs=%b addr=%h want %b addr=00000100", i, obs, jump_addr_o, exp[i]); bad++;
      end
    end
    $display("test_jump complete");
  endtask

  task automatic test_mem_hold();
    logic [4:0]  stim [7] = '{5'b10100, 5'b10100, 5'b10100, 5'b00100, 5'b00000, 5'b00000, 5'b00000};
    logic [12:0] exp  [7] = '{{5'b01111, 5'b10000, 3'b000}, {5'b01111, 5'b10000, 3'b000},
                              {5'b01111, 5'b10000, 3'b000}, {5'b00000, 5'b00110, 3'b100},
                              {5'b00000, 5'b00010, 3'b001}, {5'b00000, 5'b00010, 3'b001}, 13'b0};
    ex_jump_addr_i = 32'h0000_0200;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk); drive(stim[i]); #1;
      total++;
      if (obs !== exp[i] || (exp[i][2] && jump_addr_o !== 32'h0000_0200)) begin
        $display("FAIL mem_hold[%0d] obs=%b addr=%h want %b addr=00000200", i, obs, jump_addr_o, exp[i]); bad++;
      end
    end
    $display("test_mem_hold complete");
  endtask

  task automatic test_back_to_back();
    logic [4:0]  stim [5] = '{5'b00100, 5'b00100, 5'b00000, 5'b00000, 5'b00000};
    logic [12:0] exp  [5] = '{{5'b00000, 5'b00110, 3'b100}, {5'b00000, 5'b00110, 3'b101},
                              {5'b00000, 5'b00010, 3'b001}, {5'b00000, 5'b00010, 3'b001}, 13'b0};
    logic [31:0] want;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      ex_jump_addr_i = (i == 0) ? 32'h0000_0300 : 32'h0000_0400;
      want = ex_jump_addr_i;
      drive(stim[i]); #1;
      total++;
      if (obs !== exp[i] || (exp[i][2] && jump_addr_o !== want)) begin
        $display("FAIL back_to_back[%0d] obs=%b addr=%h want %b addr=%h", i, obs, jump_addr_o, exp[i], want); bad++;
      end
    end
    $display("test_back_to_back complete");
  endtask

  task automatic test_trap();
    logic [4:0]  stim [8] = '{5'b00010, 5'b00010, 5'b00010, 5'b00010, 5'b00010,
                              5'b00000, 5'b00000, 5'b00000};
    logic [12:0] exp  [8] = '{13'b0, {5'b00011, 5'b00100, 3'b001}, {5'b00011, 5'b00100, 3'b001},
                              {5'b00011, 5'b00100, 3'b001}, {5'b00000, 5'b00110, 3'b111},
                              {5'b00000, 5'b00010, 3'b001}, {5'b00000, 5'b00010, 3'b001}, 13'b0};
    int_addr_i = 32'h8000_0004;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); drive(stim[i]); #1;
      total++;
      if (obs !== exp[i] || (exp[i][2] && jump_addr_o !== 32'h8000_0004)) begin
        $display("FAIL trap[%0d] obs=%b addr=%h want %b addr=80000004", i, obs, jump_addr_o, exp[i]); bad++;
      end
    end
    $display("test_trap complete");
  endtask

  task automatic test_trap_hold();
    logic [4:0]  stim [10] = '{5'b00010, 5'b00010, 5'b01010, 5'b01010, 5'b00010, 5'b00010,
                               5'b00010, 5'b00000, 5'b00000, 5'b00000};
    logic [12:0] exp  [10] = '{13'b0, {5'b00011, 5'b00100, 3'b001}, {5'b00111, 5'b01000, 3'b001},
                               {5'b00111, 5'b01000, 3'b001}, {5'b00011, 5'b00100, 3'b001},
                               {5'b00011, 5'b00100, 3'b001}, {5'b00000, 5'b00110, 3'b111},
                               {5'b00000, 5'b00010, 3'b001}, {5'b00000, 5'b00010, 3'b001}, 13'b0};
    int_addr_i = 32'h8000_0040;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); drive(stim[i]); #1;
      total++;
      if (obs !== exp[i] || (exp[i][2] && jump_addr_o !== 32'h8000_0040)) begin
        $display("FAIL trap_hold[%0d] obs=%b addr=%h want %b addr=80000040", i, obs, jump_addr_o, exp[i]); bad++;
      end
    end
    $display("test_trap_hold complete");
  endtask

  // Trap deferred through a held FLUSH window, jump squashed in drain,
  // request dropped mid-drain: no ack may ever appear.
  task automatic test_defer_abort();
    logic [4:0]  stim [9] = '{5'b00100, 5'b10010, 5'b00010, 5'b00010, 5'b00010,
                              5'b00010, 5'b00110, 5'b00000, 5'b00000};
    logic [12:0] exp  [9] = '{{5'b00000, 5'b00110, 3'b100}, {5'b01111, 5'b10010, 3'b001},
                              {5'b00000, 5'b00010, 3'b001}, {5'b00000, 5'b00010, 3'b001},
                              13'b0, {5'b00011, 5'b00100, 3'b001}, {5'b00011, 5'b00110, 3'b001},
                              {5'b00011, 5'b00100, 3'b001}, 13'b0};
    ex_jump_addr_i = 32'h0000_0500;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk); drive(stim[i]); #1;
      total++;
      if (obs !== exp[i] || (exp[i][2] && jump_addr_o !== 32'h0000_0500)) begin
        $display("FAIL defer_abort[%0d] obs=%b addr=%h want %b addr=00000500", i, obs, jump_addr_o, exp[i]); bad++;
      end
    end
    $display("test_defer_abort complete");
  endtask

  initial begin
    drive(5'b00000);
    ex_jump_addr_i = '0;
    int_addr_i     = '0;
    test_reset();
    test_load_use();
    test_jump();
    test_mem_hold();
    test_back_to_back();
    test_trap();
    test_trap_hold();
    test_defer_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
